param_bank: RTL and testbench
=============================

# param_bank

Double-buffered parameter register bank that sits directly downstream of the UART packet assembler. It consumes the indexed byte stream (`read_data`, `idx`, `update_reg`) and the end-of-packet strobe (`pc_ready`). It assembles a 55-byte packet into a shadow copy, then commits it atomically to the active copy at the next frame boundary. The raster/vertex stages always see a coherent parameter set.

## Interface
- `NUM_BYTES`, 55: packet length in bytes; byte 0 is the control byte, bytes 1..54 are data.
- `WORD_W`, 16: data word width; `NUM_WORDS` = (NUM_BYTES-1)/2 = 27.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Synchronous and active-low.
- `read_data`  in  8  byte from the assembler.
- `idx`  in  6  byte index, 0..54.
- `update_reg`  in  1  one-cycle strobe: `read_data`/`idx` valid.
- `pc_ready`  in  1  one-cycle strobe: packet complete.
- `frame_start`  in  1  one-cycle strobe at frame boundary (vsync).
- `err_clr`  in  1  clears sticky errors.
- `params`  out  432  active words; word k = bits [16k+15:16k].
- `ctrl`  out  8  active control byte.
- `params_valid`  out  1  set after the first commit.
- `commit`  out  1  one-cycle pulse when active is updated.
- `pending`  out  1  a complete shadow packet is awaiting commit.
- `err`  out  2  sticky: [0] bad sequence/incomplete, [1] pending packet superseded.

## Operation
- Reset (`rst_n`=0 at an edge) clears the shadow, active `params`, `ctrl`, `params_valid`, `commit`, `pending`, `err`, and the internal `exp_idx` counter.
- Byte capture happens on `update_reg`=1:
  - `idx`=0: write `shadow_ctrl`.
  - odd `idx`=2k+1: write the low byte of shadow word k.
  - even `idx`=2k+2: write the high byte of shadow word k.
  - The data byte order is little-endian.
- Sequence check on `update_reg`:
  - If `idx` == `exp_idx`, increment `exp_idx`.
  - If `idx`=0, always restart with `exp_idx`=1. This covers both the mismatch and the resync case.
  - For any other mismatch, set `err[0]`, still write the byte, and force `exp_idx` to 63 (poisoned) until the next `idx`=0.
  - `idx` > 54: no write; set `err[0]`; poison.
- On `pc_ready`:
  - If `exp_idx` == 55, set `pending`.
  - Otherwise set `err[0]` and leave `pending` unchanged.
  - Either way, `exp_idx` goes to 0.
- Supersede: `update_reg` with `idx`=0 while `pending`=1 clears `pending` and sets `err[1]`. The newest packet wins, and no partial packet is ever committed.
- Commit: `frame_start`=1 with `pending` already 1 (registered value) does all of the following:
  - copies shadow to active;
  - pulses `commit`;
  - sets `params_valid`;
  - clears `pending`.
- `err_clr` clears `err`. A new error in the same cycle wins (stays set).

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- `update_reg` at edge N: the shadow byte is written at edge N.
- `pc_ready` at edge N: `pending`=1 from cycle N+1.
- `frame_start` at edge M with `pending`=1: `params`/`ctrl` are updated and `commit`=1 during cycle M+1; `commit`=0 at M+2.
- Simultaneous events:
  - `update_reg` + `pc_ready` in the same cycle: the byte is counted first, then the `exp_idx`==55 check.
  - `pc_ready` + `frame_start` in the same cycle: no commit in that cycle; the commit happens on the next `frame_start`.
  - `frame_start` + supersede (`idx`=0) in the same cycle: the commit takes the old shadow, the new byte 0 write is applied after the copy, and `err[1]` is not set.
- Reset mid-packet discards the partial shadow and any pending packet. Active output returns to 0 with `params_valid`=0.
- `frame_start` with `pending`=0: no effect, `commit` stays 0.

## Structure
- `gpu_param_pkg` holds:
  - `NUM_BYTES`, `NUM_WORDS`, `WORD_W`;
  - named word-index constants for the consumer stages;
  - the `err` bit positions.
- Single flat module; no sub-module is needed. Shadow and active banks are plain register arrays.

## Test plan
- Send bytes idx 0..54 with byte i = i, then `pc_ready`, then `frame_start` after 10 cycles → `commit` pulses once; `ctrl`=0x00; word 0=0x0201; word 26=0x3635; `params_valid`=1; `err`=0.
- Send idx 0..30, then `pc_ready` → `err[0]`=1, `pending`=0; a following `frame_start` gives no `commit` and active stays 0.
- Send a full packet A, then `pc_ready`, then full packet B (0xAA fill) and `pc_ready` before any `frame_start` → `err[1]`=1; the next `frame_start` commits B (all words 0xAAAA).
- Send `pc_ready` and `frame_start` in the same cycle → no `commit`; the next `frame_start` → `commit`=1 with correct data.
- Skip idx 17 in the stream, then `pc_ready` → `err[0]`=1, no `pending`. Then `err_clr` → `err`=0; a clean resend commits normally.
- Assert `rst_n`=0 for 1 cycle mid-packet after a prior commit → all outputs 0; the packet completed after reset commits cleanly.

Source files
------------

// File: rtl/gpu_param_pkg.sv
// Shared sizes, consumer word indices and error bit positions for the parameter bank.
package gpu_param_pkg;

   localparam int unsigned NUM_BYTES  = 55;
   localparam int unsigned WORD_W     = 16;
   localparam int unsigned NUM_WORDS  = (NUM_BYTES - 1) / 2;
   localparam int unsigned PARAMS_W   = NUM_WORDS * WORD_W;
   localparam int unsigned IDX_W      = 6;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned ERR_W      = 2;
   localparam int unsigned EXP_POISON = 63;

   // err bit positions
   localparam int unsigned ERR_SEQ       = 0;
   localparam int unsigned ERR_SUPERSEDE = 1;

   // word indices used by the vertex / raster consumers
   localparam int unsigned WORD_VIEW_X0    = 0;
   localparam int unsigned WORD_VIEW_Y0    = 1;
   localparam int unsigned WORD_VIEW_X1    = 2;
   localparam int unsigned WORD_VIEW_Y1    = 3;
   localparam int unsigned WORD_XFORM_BASE = 4;
   localparam int unsigned WORD_COLOR_BASE = 20;
   localparam int unsigned WORD_LAST       = NUM_WORDS - 1;

endpackage

// File: rtl/param_bank_if.sv
// Byte stream, control strobes and parameter outputs between assembler side and the bank.
interface param_bank_if;
   import gpu_param_pkg::*;

   logic [BYTE_W-1:0]   read_data;
   logic [IDX_W-1:0]    idx;
   logic                update_reg;
   logic                pc_ready;
   logic                frame_start;
   logic                err_clr;

   logic [PARAMS_W-1:0] params;
   logic [BYTE_W-1:0]   ctrl;
   logic                params_valid;
   logic                commit;
   logic                pending;
   logic [ERR_W-1:0]    err;

   modport master (
      output read_data, idx, update_reg, pc_ready, frame_start, err_clr,
      input  params, ctrl, params_valid, commit, pending, err
   );

   modport slave (
      input  read_data, idx, update_reg, pc_ready, frame_start, err_clr,
      output params, ctrl, params_valid, commit, pending, err
   );

endinterface

// File: rtl/param_bank.sv
// Double-buffered parameter bank: packets assemble into a shadow copy and are
// committed atomically to the active copy on the next frame boundary.
module param_bank
   import gpu_param_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   param_bank_if.slave bus
);

   logic [PARAMS_W-1:0] shadow_q, shadow_nx;
   logic [PARAMS_W-1:0] params_q, params_nx;
   logic [BYTE_W-1:0]   shadow_ctrl_q, shadow_ctrl_nx;
   logic [BYTE_W-1:0]   ctrl_q, ctrl_nx;
   logic                valid_q, valid_nx;
   logic                commit_q, commit_nx;
   logic                pending_q, pending_nx;
   logic [ERR_W-1:0]    err_q, err_nx;
   logic [IDX_W-1:0]    exp_q, exp_nx;

   logic                commit_now;
   logic                idx_bad;
   logic                seq_err;
   logic                supersede;

   // Next-state: commit first (takes old shadow), then byte capture/sequence, then end-of-packet.
   always_comb begin
      shadow_nx      = shadow_q;
      shadow_ctrl_nx = shadow_ctrl_q;
      params_nx      = params_q;
      ctrl_nx        = ctrl_q;
      valid_nx       = valid_q;
      commit_nx      = 1'b0;
      pending_nx     = pending_q;
      exp_nx         = exp_q;
      seq_err        = 1'b0;
      supersede      = 1'b0;

      commit_now = bus.frame_start & pending_q;
      idx_bad    = bus.idx > IDX_W'(NUM_BYTES - 1);

      if (commit_now) begin
         params_nx  = shadow_q;
         ctrl_nx    = shadow_ctrl_q;
         commit_nx  = 1'b1;
         valid_nx   = 1'b1;
         pending_nx = 1'b0;
      end

      if (bus.update_reg) begin
         if (bus.idx == '0) begin
            // byte 0 always resynchronises; a waiting packet is dropped unless it commits now
            exp_nx         = IDX_W'(1);
            shadow_ctrl_nx = bus.read_data;
            supersede      = pending_q & ~commit_now;
         end else if (idx_bad) begin
            seq_err = 1'b1;
            exp_nx  = IDX_W'(EXP_POISON);
         end else begin
            if (bus.idx == exp_q) begin
               exp_nx = exp_q + IDX_W'(1);
            end else begin
               seq_err = 1'b1;
               exp_nx  = IDX_W'(EXP_POISON);
            end
            // data byte b lands little-endian at bit offset 8*b
            for (int unsigned b = 0; b < NUM_BYTES - 1; b++) begin
               if (bus.idx == IDX_W'(b + 1)) begin
                  shadow_nx[b*BYTE_W +: BYTE_W] = bus.read_data;
               end
            end
         end
      end

      if (supersede) begin
         pending_nx = 1'b0;
      end

      if (bus.pc_ready) begin
         if (exp_nx == IDX_W'(NUM_BYTES)) begin
            pending_nx = 1'b1;
         end else begin
            seq_err = 1'b1;
         end
         exp_nx = '0;
      end

      err_nx                = bus.err_clr ? '0 : err_q;
      err_nx[ERR_SEQ]       = err_nx[ERR_SEQ] | seq_err;
      err_nx[ERR_SUPERSEDE] = err_nx[ERR_SUPERSEDE] | supersede;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q      <= '0;
         shadow_ctrl_q <= '0;
         params_q      <= '0;
         ctrl_q        <= '0;
         valid_q       <= 1'b0;
         commit_q      <= 1'b0;
         pending_q     <= 1'b0;
         err_q         <= '0;
         exp_q         <= '0;
      end else begin
         shadow_q      <= shadow_nx;
         shadow_ctrl_q <= shadow_ctrl_nx;
         params_q      <= params_nx;
         ctrl_q        <= ctrl_nx;
         valid_q       <= valid_nx;
         commit_q      <= commit_nx;
         pending_q     <= pending_nx;
         err_q         <= err_nx;
         exp_q         <= exp_nx;
      end
   end

   assign bus.params       = params_q;
   assign bus.ctrl         = ctrl_q;
   assign bus.params_valid = valid_q;
   assign bus.commit       = commit_q;
   assign bus.pending      = pending_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_param_bank.sv
// Directed bench for param_bank with a byte-array reference model checked every cycle.
module tb_param_bank;

   localparam int PW = 432;

   logic clk;
   logic rst_n;

   param_bank_if bus();

   param_bank u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   // reference model: packet bytes held as plain arrays
   logic [7:0] m_sh  [55];
   logic [7:0] m_act [55];
   int         m_exp;
   bit         m_pend, m_valid, m_cmt;
   logic [1:0] m_err;

   task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", name, got, want);
   endtask

   function automatic logic [PW-1:0] model_params();
      logic [PW-1:0] p;
      p = '0;
      for (int k = 0; k < 27; k++) p[k*16 +: 16] = {m_act[2*k+2], m_act[2*k+1]};
      return p;
   endfunction

   function automatic logic [7:0] pat(input int mode, input int i);
      case (mode)
         0: return 8'(i);
         1: return 8'hAA;
         2: return 8'(i * 3);
         3: return ~8'(i);
         4: return 8'(i + 1);
         default: return 8'(i) ^ 8'h5A;
      endcase
   endfunction

   task automatic model_step();
      bit e0, e1, fire;
      if (!rst_n) begin
         for (int i = 0; i < 55; i++) begin m_sh[i] = 8'h00; m_act[i] = 8'h00; end
         m_exp = 0; m_pend = 0; m_valid = 0; m_cmt = 0; m_err = 2'b00;
         return;
      end
      e0 = 0; e1 = 0;
      fire = bus.frame_start && m_pend;
      if (fire) begin
         for (int i = 0; i < 55; i++) m_act[i] = m_sh[i];
         m_valid = 1; m_pend = 0;
      end
      if (bus.update_reg) begin
         if (int'(bus.idx) == 0) begin
            if (m_pend) begin m_pend = 0; e1 = 1; end
            m_exp = 1;
         end else if (int'(bus.idx) > 54) begin
            e0 = 1; m_exp = 63;
         end else if (int'(bus.idx) == m_exp) begin
            m_exp = m_exp + 1;
         end else begin
            e0 = 1; m_exp = 63;
         end
         if (int'(bus.idx) <= 54) m_sh[int'(bus.idx)] = bus.read_data;
      end
      if (bus.pc_ready) begin
         if (m_exp == 55) m_pend = 1; else e0 = 1;
         m_exp = 0;
      end
      m_err = (bus.err_clr ? 2'b00 : m_err) | {e1, e0};
      m_cmt = fire;
   endtask

   // model advances on the same edge the DUT samples
   initial forever begin
      @(posedge clk);
      model_step();
      chk_en = 1;
   end

   // every-cycle compare against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("m_params",  bus.params,              model_params());
         chk("m_ctrl",    PW'(bus.ctrl),           PW'(m_act[0]));
         chk("m_valid",   PW'(bus.params_valid),   PW'(m_valid));
         chk("m_commit",  PW'(bus.commit),         PW'(m_cmt));
         chk("m_pending", PW'(bus.pending),        PW'(m_pend));
         chk("m_err",     PW'(bus.err),            PW'(m_err));
      end
   end

   task automatic beat(input bit u, input int i, input logic [7:0] d,
                       input bit pc, input bit fs, input bit ec);
      bus.update_reg  = u;
      bus.idx         = 6'(i);
      bus.read_data   = d;
      bus.pc_ready    = pc;
      bus.frame_start = fs;
      bus.err_clr     = ec;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) beat(0, 0, 8'h00, 0, 0, 0);
   endtask

   task automatic send_pkt(input int mode, input int skip, input int last);
      for (int i = 0; i <= last; i++)
         if (i != skip) beat(1, i, pat(mode, i), 0, 0, 0);
   endtask

   function automatic logic [15:0] word(input int k);
      logic [PW-1:0] p;
      p = bus.params;
      return p[k*16 +: 16];
   endfunction

   logic [PW-1:0] all_aa;

   initial begin
      rst_n = 1'b0;
      bus.update_reg = 0; bus.idx = '0; bus.read_data = '0;
      bus.pc_ready = 0; bus.frame_start = 0; bus.err_clr = 0;
      all_aa = {27{16'hAAAA}};
      @(negedge clk);
      @(negedge clk);
      chk("rst_params",  bus.params, PW'(0));
      chk("rst_valid",   PW'(bus.params_valid), PW'(0));
      chk("rst_pending", PW'(bus.pending), PW'(0));
      chk("rst_err",     PW'(bus.err), PW'(0));
      rst_n = 1'b1;

      // truncated packet
      send_pkt(0, -1, 30);
      beat(0, 0, 8'h00, 1, 0, 0);
      chk("trunc_err",     PW'(bus.err), PW'(2'b01));
      chk("trunc_pending", PW'(bus.pending), PW'(0));
      beat(0, 0, 8'h00, 0, 1, 0);
      chk("trunc_commit", PW'(bus.commit), PW'(0));
      chk("trunc_params", bus.params, PW'(0));
      chk("trunc_valid",  PW'(bus.params_valid), PW'(0));
      beat(0, 0, 8'h00, 0, 0, 1);
      chk("trunc_clr", PW'(bus.err), PW'(0));

      // clean packet, byte i = i
      send_pkt(0, -1, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      chk("t1_pending", PW'(bus.pending), PW'(1));
      idle(10);
      beat(0, 0, 8'h00, 0, 1, 0);
      chk("t1_commit", PW'(bus.commit), PW'(1));
      chk("t1_ctrl",   PW'(bus.ctrl), PW'(8'h00));
      chk("t1_w0",     PW'(word(0)), PW'(16'h0201));
      chk("t1_w26",    PW'(word(26)), PW'(16'h3635));
      chk("t1_valid",  PW'(bus.params_valid), PW'(1));
      chk("t1_err",    PW'(bus.err), PW'(0));
      idle(1);
      chk("t1_commit_end", PW'(bus.commit), PW'(0));

      // superseded pending packet
      send_pkt(2, -1, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      send_pkt(1, -1, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      chk("sup_err",     PW'(bus.err), PW'(2'b10));
      chk("sup_pending", PW'(bus.pending), PW'(1));
      beat(0, 0, 8'h00, 0, 1, 0);
      chk("sup_commit", PW'(bus.commit), PW'(1));
      chk("sup_params", bus.params, all_aa);
      chk("sup_ctrl",   PW'(bus.ctrl), PW'(8'hAA));
      beat(0, 0, 8'h00, 0, 0, 1);

      // pc_ready and frame_start together
      send_pkt(2, -1, 54);
      beat(0, 0, 8'h00, 1, 1, 0);
      chk("same_commit",  PW'(bus.commit), PW'(0));
      chk("same_pending", PW'(bus.pending), PW'(1));
      idle(1);
      beat(0, 0, 8'h00, 0, 1, 0);
      chk("same_commit2", PW'(bus.commit), PW'(1));
      chk("same_w0",      PW'(word(0)), PW'(16'h0603));
      chk("same_w26",     PW'(word(26)), PW'(16'hA29F));

      // skipped index
      send_pkt(3, 17, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      chk("skip_err",     PW'(bus.err), PW'(2'b01));
      chk("skip_pending", PW'(bus.pending), PW'(0));
      beat(0, 0, 8'h00, 0, 0, 1);
      chk("skip_clr", PW'(bus.err), PW'(0));
      send_pkt(3, -1, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      beat(0, 0, 8'h00, 0, 1, 0);
      chk("resend_commit", PW'(bus.commit), PW'(1));
      chk("resend_w0",     PW'(word(0)), PW'(16'hFDFE));
      chk("resend_err",    PW'(bus.err), PW'(0));

      // reset mid-packet
      send_pkt(0, -1, 20);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      chk("mrst_params",  bus.params, PW'(0));
      chk("mrst_ctrl",    PW'(bus.ctrl), PW'(0));
      chk("mrst_valid",   PW'(bus.params_valid), PW'(0));
      chk("mrst_pending", PW'(bus.pending), PW'(0));
      chk("mrst_commit",  PW'(bus.commit), PW'(0));
      send_pkt(4, -1, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      beat(0, 0, 8'h00, 0, 1, 0);
      chk("mrst_commit2", PW'(bus.commit), PW'(1));
      chk("mrst_ctrl2",   PW'(bus.ctrl), PW'(8'h01));
      chk("mrst_w0",      PW'(word(0)), PW'(16'h0302));
      chk("mrst_valid2",  PW'(bus.params_valid), PW'(1));

      // commit coinciding with a new byte 0, then out-of-range index
      send_pkt(5, -1, 54);
      beat(0, 0, 8'h00, 1, 0, 0);
      beat(1, 0, 8'h77, 0, 1, 0);
      chk("fsup_commit",  PW'(bus.commit), PW'(1));
      chk("fsup_ctrl",    PW'(bus.ctrl), PW'(8'h5A));
      chk("fsup_err",     PW'(bus.err), PW'(0));
      chk("fsup_pending", PW'(bus.pending), PW'(0));
      beat(1, 60, 8'h12, 0, 0, 0);
      chk("oor_err", PW'(bus.err), PW'(2'b01));
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
